mux2_arbiter: RTL and testbench

MUX2_ARBITER -- requirements
Module: mux2_arbiter

---
 rtl/mux2_arbiter.sv | 129 ++++++++++++
 tb/tb_mux2_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// Two-requester burst arbiter driving a shared output port through a select mux.
// Build option: MUX2_ARB_FIXED_PRIORITY_EN makes A win every tie in place of round-robin.
module mux2_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_last,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_last,
   output logic             b_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             sel,
   output logic             grant_a,
   output logic             grant_b,
   output logic             busy
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sel_q, sel_d;
   logic             tie_pick_b;
   logic             xfer;
   logic             beat_last;

   // State, burst counter and held mux select
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
      end
   end

`ifdef MUX2_ARB_FIXED_PRIORITY_EN
   assign tie_pick_b = 1'b0;
`else
   logic last_b_q;

   // Remembers the most recent grant; reset to B so A wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_b_q <= 1'b1;
      end else if (state_q == IDLE && state_d != IDLE) begin
         last_b_q <= (state_d == GNT_B);
      end
   end

   assign tie_pick_b = ~last_b_q;
`endif

   // Next-state, counter and mux/handshake decode
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      out_valid = 1'b0;
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      busy      = 1'b0;
      xfer      = 1'b0;
      beat_last = 1'b0;

      case (state_q)
         IDLE: begin
            if (a_valid && (!b_valid || !tie_pick_b)) begin
               state_d = GNT_A;
               sel_d   = 1'b0;
            end else if (b_valid) begin
               state_d = GNT_B;
               sel_d   = 1'b1;
            end
         end
         GNT_A: begin
            grant_a   = 1'b1;
            busy      = 1'b1;
            // Reset in this cycle suppresses the handshake so no beat is lost upstream
            out_valid = a_valid & ~rst;
            a_ready   = out_ready & ~rst;
            xfer      = a_valid & out_ready;
            beat_last = a_last;
         end
         GNT_B: begin
            grant_b   = 1'b1;
            busy      = 1'b1;
            out_valid = b_valid & ~rst;
            b_ready   = out_ready & ~rst;
            xfer      = b_valid & out_ready;
            beat_last = b_last;
         end
         default: state_d = IDLE;
      endcase

      if (xfer) begin
         if (beat_last || (cnt_q + CNT_W'(1)) == BURST_MAX) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign sel      = sel_q;
   assign out_data = sel_q ? b_data : a_data;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: driver feeds a transaction-level model, monitor compares.
module tb_mux2_arbiter;

   localparam int unsigned WIDTH     = 8;
   localparam int unsigned MAX_BURST = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             a_valid, a_last, a_ready;
   logic             b_valid, b_last, b_ready;
   logic [WIDTH-1:0] a_data, b_data, out_data;
   logic             out_valid, out_ready;
   logic             sel, grant_a, grant_b, busy;

   always #5 clk = ~clk;

   mux2_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .sel(sel), .grant_a(grant_a), .grant_b(grant_b), .busy(busy)
   );

   typedef struct packed {
      logic             ga;
      logic             gb;
      logic             busy;
      logic             sel;
      logic             ov;
      logic             ar;
      logic             br;
      logic [WIDTH-1:0] od;
   } exp_t;

   exp_t             exp_q[$];
   logic [WIDTH:0]   xfer_q[$];
   int               tests = 0;
   int               fails = 0;

   // Reference model: owner 0=none 1=A 2=B, beats taken in this grant, last winner
   int               owner = 0;
   int               beats = 0;
   int               last_win = 2;
   logic             m_sel = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic av, input logic bv, input logic al,
                        input logic bl, input logic ordy,
                        input logic [WIDTH-1:0] ad, input logic [WIDTH-1:0] bd);
      exp_t e;
      logic xf;
      logic lst;
      @(posedge clk);
      #1;
      rst = r; a_valid = av; b_valid = bv; a_last = al; b_last = bl;
      out_ready = ordy; a_data = ad; b_data = bd;

      e.ga   = (owner == 1);
      e.gb   = (owner == 2);
      e.busy = (owner != 0);
      e.sel  = m_sel;
      e.od   = m_sel ? bd : ad;
      e.ov   = !r && ((owner == 1 && av) || (owner == 2 && bv));
      e.ar   = !r && (owner == 1) && ordy;
      e.br   = !r && (owner == 2) && ordy;
      exp_q.push_back(e);

      xf = e.ov && ordy;
      if (xf) xfer_q.push_back({owner == 2, (owner == 2) ? bd : ad});

      if (r) begin
         owner = 0; beats = 0; m_sel = 1'b0; last_win = 2;
      end else if (owner == 0) begin
         if (av && bv) begin
`ifdef MUX2_ARB_FIXED_PRIORITY_EN
            owner = 1;
`else
            owner = (last_win == 1) ? 2 : 1;
`endif
         end else if (av) begin
            owner = 1;
         end else if (bv) begin
            owner = 2;
         end
         if (owner != 0) begin
            last_win = owner;
            m_sel    = (owner == 2);
         end
      end else if (xf) begin
         beats++;
         lst = (owner == 1) ? al : bl;
         if (lst || beats == int'(MAX_BURST)) begin
            owner = 0;
            beats = 0;
         end
      end
   endtask

   function automatic logic [WIDTH-1:0] rnd();
      return WIDTH'($urandom);
   endfunction

   // Monitor: per-cycle status plus transfer scoreboard
   exp_t           mon_e;
   logic [WIDTH:0] mon_x;
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("grant_a",   32'(grant_a),   32'(mon_e.ga));
            check("grant_b",   32'(grant_b),   32'(mon_e.gb));
            check("busy",      32'(busy),      32'(mon_e.busy));
            check("sel",       32'(sel),       32'(mon_e.sel));
            check("out_valid", 32'(out_valid), 32'(mon_e.ov));
            check("a_ready",   32'(a_ready),   32'(mon_e.ar));
            check("b_ready",   32'(b_ready),   32'(mon_e.br));
            check("out_data",  32'(out_data),  32'(mon_e.od));
            check("grant_excl", 32'(grant_a & grant_b), 32'(0));
         end
         if (out_valid && out_ready) begin
            if (xfer_q.size() == 0) begin
               check("xfer_expected", 32'(1), 32'(0));
            end else begin
               mon_x = xfer_q.pop_front();
               check("xfer_src",  32'(sel),      32'(mon_x[WIDTH]));
               check("xfer_data", 32'(out_data), 32'(mon_x[WIDTH-1:0]));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_last = 1'b0; b_last = 1'b0;
      out_ready = 1'b0; a_data = '0; b_data = '0;

      // Reset held with both requesting, then release
      repeat (2) drive(1, 1, 1, 0, 0, 0, rnd(), rnd());

      // Ties with single-beat bursts
      repeat (12) drive(0, 1, 1, 1, 1, 1, 8'h11, 8'h22);

      // Long bursts capped by MAX_BURST, B waiting
      repeat (14) drive(0, 1, 1, 0, 0, 1, rnd(), rnd());

      // Backpressure while A holds the grant
      drive(1, 0, 0, 0, 0, 0, rnd(), rnd());
      repeat (6) drive(0, 1, 0, 0, 0, 0, rnd(), rnd());
      repeat (3) drive(0, 1, 0, 0, 0, 1, rnd(), rnd());
      drive(0, 1, 0, 1, 0, 1, rnd(), rnd());

      // Reset in the middle of a B burst, then a tie
      repeat (3) drive(0, 0, 1, 0, 0, 1, rnd(), rnd());
      drive(1, 1, 1, 0, 0, 1, rnd(), rnd());
      repeat (4) drive(0, 1, 1, 1, 1, 1, rnd(), rnd());

      // Randomized traffic with occasional reset
      repeat (600) begin
         drive(logic'($urandom_range(0, 49) == 0),
               logic'($urandom_range(0, 3) != 0),
               logic'($urandom_range(0, 3) != 0),
               logic'($urandom_range(0, 2) == 0),
               logic'($urandom_range(0, 2) == 0),
               logic'($urandom_range(0, 3) != 0),
               rnd(), rnd());
      end

      repeat (2) drive(0, 0, 0, 0, 0, 0, rnd(), rnd());
      @(negedge clk);
      #1;
      check("xfer_q_drained", 32'(xfer_q.size()), 32'(0));
      check("exp_q_drained",  32'(exp_q.size()),  32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
